// File: rtl/alu_accum_seq_pkg.sv
// Shared definitions for the accumulator ALU: opcodes, FSM states, flag layout.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd2;
    localparam logic [OP_W-1:0] OP_AND  = 4'd3;
    localparam logic [OP_W-1:0] OP_OR   = 4'd4;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
    localparam logic [OP_W-1:0] OP_PASS = 4'd7;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd8;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd9;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // Bit positions inside the packed flag register.
    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_N     = 3;

    // Opcodes 10..15 are never legal; MUL is legal only when the multiplier is built.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op, input logic mul_en);
        return (op <= OP_SHR) && ((op != OP_MUL) || mul_en);
    endfunction

endpackage

// File: rtl/alu_accum_seq_if.sv
// Operation request / result bus between command decoder and the accumulator ALU.
interface alu_accum_seq_if #(parameter int W = 8);
    logic         op_valid;
    logic         op_ready;
    logic [3:0]   op_code;
    logic         use_acc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         res_valid;
    logic         flag_zero;
    logic         flag_carry;
    logic         flag_ovf;
    logic         err;

    modport master (
        output op_valid, op_code, use_acc, a, b,
        input  op_ready, result, res_valid, flag_zero, flag_carry, flag_ovf, err
    );

    modport slave (
        input  op_valid, op_code, use_acc, a, b,
        output op_ready, result, res_valid, flag_zero, flag_carry, flag_ovf, err
    );
endinterface

// File: rtl/alu_accum_seq_mul.sv
// W-cycle shift-add multiplier. 'product' shows the running sum after the
// current cycle's step, so the owner can capture it on the edge where 'done' is high.
module seq_multiplier #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           abort,
    input  logic           start,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic [2*W-1:0] step_sum_s;

    assign step_sum_s = prod_q + (mplier_q[0] ? mcand_q : {(2*W){1'b0}});
    assign product    = step_sum_s;
    assign busy       = busy_q;
    assign done       = busy_q && (cnt_q == CW'(1));

    // Next state: abort wins, then load on start, otherwise one shift-add step per cycle.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (abort) begin
            busy_d = 1'b0;
            cnt_d  = {CW{1'b0}};
        end else if (start) begin
            mcand_d  = {{W{1'b0}}, x};
            mplier_d = y;
            prod_d   = {(2*W){1'b0}};
            cnt_d    = CW'(W);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            prod_d   = step_sum_s;
            mcand_d  = {mcand_q[2*W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[W-1:1]};
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= {(2*W){1'b0}};
            mplier_q <= {W{1'b0}};
            prod_q   <= {(2*W){1'b0}};
            cnt_q    <= {CW{1'b0}};
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end
endmodule

// File: rtl/alu_accum_seq.sv
// Accumulator ALU: single-cycle ops update on accept, MUL runs the sequential
// multiplier for W cycles. clr clears state and aborts any multiply.
module alu_accum_seq
    import alu_pkg::*;
#(
    parameter int W      = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    alu_accum_seq_if.slave bus
);
    state_e         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [2:0]     flags_q, flags_d;
    logic           res_valid_q, res_valid_d;
    logic           err_q, err_d;

    logic [W-1:0]   x_s, y_s;
    logic [W:0]     sum_s, diff_s;
    logic [W-1:0]   alu_res_s;
    logic           alu_c_s, alu_v_s;
    logic           legal_s, is_mul_s, mul_start_s;
    logic           mul_busy_s, mul_done_s;
    logic [2*W-1:0] mul_prod_s;

    assign x_s      = bus.use_acc ? acc_q : bus.a;
    assign y_s      = bus.use_acc ? bus.a : bus.b;
    assign sum_s    = {1'b0, x_s} + {1'b0, y_s};
    assign diff_s   = {1'b0, x_s} - {1'b0, y_s};
    assign legal_s  = op_is_legal(bus.op_code, MUL_EN);
    assign is_mul_s = (bus.op_code == OP_MUL);

    seq_multiplier #(.W(W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .abort   (clr),
        .start   (mul_start_s),
        .x       (x_s),
        .y       (y_s),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    // Single-cycle ALU result and carry/overflow for the current opcode.
    always_comb begin
        alu_res_s = x_s;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (bus.op_code)
            OP_ADD: begin
                alu_res_s = sum_s[W-1:0];
                alu_c_s   = sum_s[W];
                alu_v_s   = (x_s[W-1] == y_s[W-1]) && (sum_s[W-1] != x_s[W-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s[W-1:0];
                alu_c_s   = diff_s[W];
                alu_v_s   = (x_s[W-1] != y_s[W-1]) && (diff_s[W-1] != x_s[W-1]);
            end
            OP_AND:  alu_res_s = x_s & y_s;
            OP_OR:   alu_res_s = x_s | y_s;
            OP_NOT:  alu_res_s = ~x_s;
            OP_XOR:  alu_res_s = x_s ^ y_s;
            OP_PASS: alu_res_s = x_s;
            OP_SHL: begin
                alu_res_s = {x_s[W-2:0], 1'b0};
                alu_c_s   = x_s[W-1];
            end
            OP_SHR: begin
                alu_res_s = {1'b0, x_s[W-1:1]};
                alu_c_s   = x_s[0];
            end
            default: alu_res_s = x_s;
        endcase
    end

    // Control FSM plus accumulator/flag next state; clr overrides everything.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        flags_d     = flags_q;
        res_valid_d = 1'b0;
        err_d       = 1'b0;
        mul_start_s = 1'b0;
        if (clr) begin
            state_d = ST_IDLE;
            acc_d   = {W{1'b0}};
            flags_d = 3'b000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.op_valid) begin
                        if (!legal_s) begin
                            err_d = 1'b1;
                        end else if (is_mul_s) begin
                            mul_start_s = 1'b1;
                            state_d     = ST_MUL;
                        end else begin
                            acc_d              = alu_res_s;
                            flags_d[FLG_ZERO]  = (alu_res_s == {W{1'b0}});
                            flags_d[FLG_CARRY] = alu_c_s;
                            flags_d[FLG_OVF]   = alu_v_s;
                            res_valid_d        = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (mul_busy_s && mul_done_s) begin
                        acc_d              = mul_prod_s[W-1:0];
                        flags_d[FLG_ZERO]  = (mul_prod_s[W-1:0] == {W{1'b0}});
                        flags_d[FLG_CARRY] = (mul_prod_s[2*W-1:W] != {W{1'b0}});
                        flags_d[FLG_OVF]   = (mul_prod_s[2*W-1:W] != {W{1'b0}});
                        res_valid_d        = 1'b1;
                        state_d            = ST_IDLE;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, accumulator, flags and output pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= {W{1'b0}};
            flags_q     <= 3'b000;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            flags_q     <= flags_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.op_ready   = (state_q == ST_IDLE);
    assign bus.result     = acc_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.flag_zero  = flags_q[FLG_ZERO];
    assign bus.flag_carry = flags_q[FLG_CARRY];
    assign bus.flag_ovf   = flags_q[FLG_OVF];
    assign bus.err        = err_q;
endmodule

// File: tb/tb_alu_accum_seq.sv
// Directed bench for alu_accum_seq (W=8). Expected results are queued when an
// op is issued and compared when res_valid is seen; a second instance is built
// without the multiplier.
module tb_alu_accum_seq;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_accum_seq_if #(.W(W)) u0 ();
    alu_accum_seq_if #(.W(W)) u1 ();

    alu_accum_seq #(.W(W), .MUL_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(u0.slave));
    alu_accum_seq #(.W(W), .MUL_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(u1.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] r, input logic z, input logic c, input logic v);
        exp_t e;
        e.res = r; e.z = z; e.c = c; e.v = v;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [3:0] code, input logic ua, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        u0.op_valid = 1'b1; u0.op_code = code; u0.use_acc = ua; u0.a = av; u0.b = bv;
        @(posedge clk);
        #1;
        u0.op_valid = 1'b0;
    endtask

    task automatic issue1(input logic [3:0] code, input logic [W-1:0] av);
        @(negedge clk);
        u1.op_valid = 1'b1; u1.op_code = code; u1.use_acc = 1'b0; u1.a = av; u1.b = 8'h00;
        @(posedge clk);
        #1;
        u1.op_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (u0.op_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk(tag, {31'd0, u0.op_ready}, 32'd1);
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clk);
        #1;
        chk(tag, sb.size(), 32'd0);
    endtask

    // Scoreboard: every res_valid cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t got, e;
        if (rst_n === 1'b1 && u0.res_valid === 1'b1) begin
            got.res = u0.result; got.z = u0.flag_zero; got.c = u0.flag_carry; got.v = u0.flag_ovf;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_res_valid: observed res=%0h z=%0b c=%0b v=%0b expected no res_valid",
                       got.res, got.z, got.c, got.v);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                assert (got === e) else begin
                    errors++;
                    $error("FAIL result_flags: observed res=%0h z=%0b c=%0b v=%0b expected res=%0h z=%0b c=%0b v=%0b",
                           got.res, got.z, got.c, got.v, e.res, e.z, e.c, e.v);
                end
            end
        end
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        u0.op_valid = 1'b0; u0.op_code = 4'd0; u0.use_acc = 1'b0; u0.a = 8'h00; u0.b = 8'h00;
        u1.op_valid = 1'b0; u1.op_code = 4'd0; u1.use_acc = 1'b0; u1.a = 8'h00; u1.b = 8'h00;
        clr = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("reset_result", {24'd0, u0.result}, 32'd0);
        chk("reset_flags", {29'd0, u0.flag_zero, u0.flag_carry, u0.flag_ovf}, 32'd0);
        chk("reset_res_valid", {31'd0, u0.res_valid}, 32'd0);
        chk("reset_err", {31'd0, u0.err}, 32'd0);
        chk("reset_op_ready", {31'd0, u0.op_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: ADD with unsigned carry, no signed overflow.
        push(8'd44, 1'b0, 1'b1, 1'b0);
        issue(OP_ADD, 1'b0, 8'd200, 8'd100);
        chk("add_res_valid", {31'd0, u0.res_valid}, 32'd1);
        drain("add_drain");

        // 2: SUB with signed overflow, then reuse acc to reach zero.
        push(8'h7F, 1'b0, 1'b0, 1'b1);
        issue(OP_SUB, 1'b0, 8'h80, 8'h01);
        push(8'h00, 1'b1, 1'b0, 1'b0);
        issue(OP_SUB, 1'b1, 8'h7F, 8'h00);
        drain("sub_drain");

        // 3: MUL 15*17, inputs wiggled and op_valid held while busy.
        push(8'd255, 1'b0, 1'b0, 1'b0);
        issue(OP_MUL, 1'b0, 8'd15, 8'd17);
        n = 0;
        u0.op_valid = 1'b1; u0.op_code = OP_ADD;
        @(negedge clk);
        while (u0.op_ready !== 1'b1 && n < 20) begin
            n++;
            u0.a = 8'($urandom); u0.b = 8'($urandom); u0.use_acc = 1'($urandom);
            @(negedge clk);
        end
        u0.op_valid = 1'b0;
        chk("mul_busy_cycles", n, 32'd8);
        push(8'hFE, 1'b0, 1'b1, 1'b1);
        issue(OP_MUL, 1'b1, 8'd2, 8'd0);
        wait_idle("mul2_idle");
        drain("mul_drain");

        // 4: back-to-back logic/shift chain on the accumulator.
        push(8'h0F, 1'b0, 1'b0, 1'b0);
        issue(OP_PASS, 1'b0, 8'h0F, 8'h00);
        push(8'h00, 1'b1, 1'b0, 1'b0);
        issue(OP_XOR, 1'b1, 8'h0F, 8'h00);
        push(8'hFF, 1'b0, 1'b0, 1'b0);
        issue(OP_NOT, 1'b1, 8'h00, 8'h00);
        push(8'hFE, 1'b0, 1'b1, 1'b0);
        issue(OP_SHL, 1'b1, 8'h00, 8'h00);
        push(8'h7F, 1'b0, 1'b0, 1'b0);
        issue(OP_SHR, 1'b1, 8'h00, 8'h00);
        drain("chain_drain");

        // 5a: clr in the third busy cycle aborts the multiply.
        issue(OP_MUL, 1'b0, 8'd3, 8'd3);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_result", {24'd0, u0.result}, 32'd0);
        chk("clr_op_ready", {31'd0, u0.op_ready}, 32'd1);
        chk("clr_res_valid", {31'd0, u0.res_valid}, 32'd0);
        chk("clr_err", {31'd0, u0.err}, 32'd0);
        repeat (12) @(negedge clk);
        chk("clr_no_late_result", {24'd0, u0.result}, 32'd0);

        // 5b: async reset mid-multiply acts without a clock edge.
        push(8'h33, 1'b0, 1'b0, 1'b0);
        issue(OP_PASS, 1'b0, 8'h33, 8'h00);
        issue(OP_MUL, 1'b0, 8'd3, 8'd3);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mul_result", {24'd0, u0.result}, 32'd0);
        chk("rst_mid_mul_op_ready", {31'd0, u0.op_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst_no_pending", {24'd0, u0.result}, 32'd0);
        chk("rst_drain", sb.size(), 32'd0);

        // 6: illegal opcode leaves acc alone and pulses err.
        push(8'h55, 1'b0, 1'b0, 1'b0);
        issue(OP_PASS, 1'b0, 8'h55, 8'h00);
        issue(4'hF, 1'b0, 8'h12, 8'h34);
        chk("illegal_err", {31'd0, u0.err}, 32'd1);
        chk("illegal_res_valid", {31'd0, u0.res_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("illegal_err_pulse", {31'd0, u0.err}, 32'd0);
        chk("illegal_result", {24'd0, u0.result}, 32'h55);

        // 6b: MUL rejected when the multiplier is not built.
        issue1(OP_PASS, 8'h55);
        chk("nomul_pass", {24'd0, u1.result}, 32'h55);
        issue1(OP_MUL, 8'h03);
        chk("nomul_err", {31'd0, u1.err}, 32'd1);
        chk("nomul_res_valid", {31'd0, u1.res_valid}, 32'd0);
        chk("nomul_op_ready", {31'd0, u1.op_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("nomul_err_pulse", {31'd0, u1.err}, 32'd0);
        chk("nomul_result", {24'd0, u1.result}, 32'h55);
        drain("final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
